dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 12, sets the word address width of the dmem port.
REQ-002 Parameter DATA_W, default 32, sets the data width.
REQ-003 Parameter BURST_MAX, default 4, sets the maximum consecutive transfers per ownership when the other port is requesting (legal range 1..15).
REQ-004 clock  in  1  single clock for the block; the arbiter SHALL use the same edge as the processor clock.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 req0, req1  in  1 each  access request from port 0 (processor) and port 1 (loader/debug).
REQ-007 wen0, wen1  in  1 each  1 = write, 0 = read; qualified by reqN.
REQ-008 addr0, addr1  in  ADDR_W each  word address.
REQ-009 wdata0, wdata1  in  DATA_W each  write data.
REQ-010 gnt0, gnt1  out  1 each  transfer accepted this cycle.
REQ-011 rvalid0, rvalid1  out  1 each  read data valid on rdataN this cycle.
REQ-012 rdata0, rdata1  out  DATA_W each  read data.
REQ-013 mem_address  out  ADDR_W  to dmem address.
REQ-014 mem_data  out  DATA_W  to dmem data.
REQ-015 mem_wren  out  1  to dmem write enable.
REQ-016 mem_q  in  DATA_W  from dmem; valid one clock after the address is presented.

Function
REQ-017 FSM states: IDLE, OWN0, OWN1, held in a registered state; lastN register records the most recent owner.
REQ-018 gntN SHALL equal (state==OWNN) && reqN, combinationally; a transfer occurs in any cycle with reqN && gntN.
REQ-019 mem_address/mem_data SHALL follow the owning port; in IDLE both SHALL be 0.
REQ-020 mem_wren SHALL equal transfer && wenN of the owner; it SHALL never be 1 without a transfer.
REQ-021 rvalidN SHALL be registered: high exactly one cycle after a read transfer on port N, otherwise 0.
REQ-022 rdataN SHALL pass mem_q when rvalidN is 1, and 0 otherwise.
REQ-023 IDLE: only reqN -> OWNN next cycle; both -> tie-break per REQ-030/031; neither -> stay. The first gnt therefore arrives one cycle after req from IDLE.
REQ-024 OWNN with reqN low: other port requesting -> OWN(other); otherwise -> IDLE.
REQ-025 beat_cnt (4 bits) counts transfers in the current ownership; it clears on every state change and on entering IDLE.
REQ-026 OWNN, transfer with beat_cnt == BURST_MAX-1 and other port requesting -> OWN(other) next cycle; without the other request, stay and saturate beat_cnt at BURST_MAX-1.
REQ-027 A read granted in the final cycle of ownership SHALL still produce its rvalid on the correct port the following cycle.
REQ-028 Both ports SHALL never be granted in the same cycle.

Reset
REQ-029 On reset: state=IDLE, last=1 (port 0 wins the first tie), beat_cnt=0, gnt0=gnt1=0, rvalid0=rvalid1=0, mem_wren=0, mem_address=0, mem_data=0. A pending rvalid is dropped when reset occurs mid-operation.

Configuration
REQ-030 With DMEM_ARB_RR_EN defined: IDLE ties go to the port not equal to last; the BURST_MAX limit of REQ-026 applies to both ports.
REQ-031 Without DMEM_ARB_RR_EN: fixed priority. Port 0 wins every tie. In OWN1, req0 high forces OWN0 next cycle regardless of beat_cnt. Port 0 is never burst-limited. The lastN register SHALL be absent.

Verification
REQ-032 After reset, req0=1, wen0=1, addr0=5, wdata0=0xDEADBEEF -> gnt0=1 on the 2nd cycle with mem_wren=1, mem_address=5.
REQ-033 Port 1 reads addr 5 after REQ-032 -> rvalid1=1 with rdata1=0xDEADBEEF one cycle after gnt1; rvalid0 stays 0.
REQ-034 req0 and req1 held high continuously, BURST_MAX=4, DMEM_ARB_RR_EN defined -> grants alternate 4×gnt0, 4×gnt1, repeating, with no idle cycle between bursts.
REQ-035 Same stimulus without DMEM_ARB_RR_EN -> gnt0 every cycle, gnt1 never.
REQ-036 Reset asserted in the cycle after a port 0 read transfer -> rvalid0=0 next cycle, state IDLE, all grants 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-port arbiter in front of a single-port data memory. Port 0 is the
//   processor, port 1 is the loader/debug port. Ownership is tracked by a
//   small FSM (IDLE / OWN0 / OWN1). The owner's request is granted
//   combinationally. Read data returns one cycle after the read transfer.
//
//   Optional feature macro: DMEM_ARB_RR_EN
//     defined   : IDLE ties go to the port that did not own last; both ports
//                 are limited to BURST_MAX transfers while the other waits.
//     undefined : fixed priority, port 0 wins ties and preempts port 1.
//
// Ports
//   clock, reset            : single clock, synchronous active-high reset
//   req/wen/addr/wdata 0,1  : request, write enable, word address, write data
//   gnt0, gnt1              : transfer accepted this cycle
//   rvalid0/1, rdata0/1     : read return, one cycle after the read transfer
//   mem_address/data/wren   : dmem request side
//   mem_q                   : dmem read data (one cycle latency)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int BURST_MAX = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              wen0,
    input  logic              wen1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] BEAT_LAST = 4'(BURST_MAX - 1);

    state_t     state_q, state_d;
    logic [3:0] beat_cnt, beat_cnt_d;
    logic       rvld0_p1, rvld1_p1;

`ifdef DMEM_ARB_RR_EN
    logic       last_q, last_d;
`endif

    // Beat counter holds at the last beat so a lone requester can keep
    // the port indefinitely and still hand over as soon as the other asks.
    function automatic logic [3:0] beat_inc_sat(input logic [3:0] cnt);
        return (cnt == BEAT_LAST) ? cnt : cnt + 4'd1;
    endfunction

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt;
        gnt0        = 1'b0;
        gnt1        = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
`ifdef DMEM_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef DMEM_ARB_RR_EN
                // last_q == 1 means port 1 owned last, so port 0 wins the tie
                if (req0 && req1) state_d = last_q ? OWN0 : OWN1;
                else
`endif
                if (req0)      state_d = OWN0;
                else if (req1) state_d = OWN1;
            end
            OWN0: begin
                gnt0        = req0;
                mem_address = addr0;
                mem_data    = wdata0;
                mem_wren    = req0 && wen0;
                if (!req0) state_d = req1 ? OWN1 : IDLE;
`ifdef DMEM_ARB_RR_EN
                else if (req1 && beat_cnt == BEAT_LAST) state_d = OWN1;
`endif
            end
            OWN1: begin
                gnt1        = req1;
                mem_address = addr1;
                mem_data    = wdata1;
                mem_wren    = req1 && wen1;
                if (!req1) state_d = req0 ? OWN0 : IDLE;
`ifdef DMEM_ARB_RR_EN
                else if (req0 && beat_cnt == BEAT_LAST) state_d = OWN0;
`else
                else if (req0) state_d = OWN0;
`endif
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q || state_q == IDLE) beat_cnt_d = 4'd0;
        else if (gnt0 || gnt1)                     beat_cnt_d = beat_inc_sat(beat_cnt);

`ifdef DMEM_ARB_RR_EN
        if (state_d == OWN0)      last_d = 1'b0;
        else if (state_d == OWN1) last_d = 1'b1;
`endif
    end

    // Stage p0 -> p1: ownership state and read-return flags
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            beat_cnt <= 4'd0;
            rvld0_p1 <= 1'b0;
            rvld1_p1 <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            beat_cnt <= beat_cnt_d;
            // Tagged by the port granted now, so a read in the last cycle
            // of an ownership still returns to its own port.
            rvld0_p1 <= gnt0 && !wen0;
            rvld1_p1 <= gnt1 && !wen1;
`ifdef DMEM_ARB_RR_EN
            last_q   <= last_d;
`endif
        end
    end

    assign rvalid0 = rvld0_p1;
    assign rvalid1 = rvld1_p1;
    assign rdata0  = rvld0_p1 ? mem_q : '0;
    assign rdata1  = rvld1_p1 ? mem_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clock;
    logic              reset;
    logic              req0, req1, wen0, wen1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              gnt0, gnt1, rvalid0, rvalid1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data;
    logic              mem_wren;
    logic [DATA_W-1:0] mem_q;

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    int n_checks;
    int n_errors;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_MAX(4)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .wen0(wen0), .wen1(wen1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .mem_q(mem_q)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous single-port memory, one cycle read latency
    always @(posedge clock) begin
        if (mem_wren) mem[mem_address] <= mem_data;
        mem_q <= mem[mem_address];
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic adv;
        @(posedge clock);
        #1;
    endtask

    task automatic chk_gnt(input string tag, input logic e0, input logic e1);
        check_val({tag, "_gnt0"}, 64'(gnt0), 64'(e0));
        check_val({tag, "_gnt1"}, 64'(gnt1), 64'(e1));
    endtask

    logic exp_g0, exp_g1, prev_g0, prev_g1;
    logic [ADDR_W-1:0] exp_addr;
    int   npre;
    logic pre_g0 [0:3];
    logic pre_g1 [0:3];

    initial begin
        n_checks = 0;
        n_errors = 0;
        reset = 1'b1;
        req0 = 0; req1 = 0; wen0 = 0; wen1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk_gnt("rst", 1'b0, 1'b0);
        check_val("rst_rvalid0", 64'(rvalid0), 64'd0);
        check_val("rst_rvalid1", 64'(rvalid1), 64'd0);
        check_val("rst_wren", 64'(mem_wren), 64'd0);
        check_val("rst_addr", 64'(mem_address), 64'd0);
        check_val("rst_data", 64'(mem_data), 64'd0);
        adv();
        reset = 1'b0;

        // Port 0 write: grant arrives on the second cycle
        req0 = 1; wen0 = 1; addr0 = 12'd5; wdata0 = 32'hDEADBEEF;
        @(negedge clock);
        chk_gnt("wr_c1", 1'b0, 1'b0);
        check_val("wr_c1_wren", 64'(mem_wren), 64'd0);
        check_val("idle_addr", 64'(mem_address), 64'd0);
        adv();
        @(negedge clock);
        chk_gnt("wr_c2", 1'b1, 1'b0);
        check_val("wr_c2_wren", 64'(mem_wren), 64'd1);
        check_val("wr_c2_addr", 64'(mem_address), 64'd5);
        check_val("wr_c2_data", 64'(mem_data), 64'hDEADBEEF);
        adv();
        req0 = 0; wen0 = 0;
        @(negedge clock);
        chk_gnt("wr_rel", 1'b0, 1'b0);
        check_val("wr_rel_wren", 64'(mem_wren), 64'd0);
        check_val("wr_no_rvalid0", 64'(rvalid0), 64'd0);
        adv();

        // Port 1 reads back address 5
        req1 = 1; wen1 = 0; addr1 = 12'd5;
        @(negedge clock);
        chk_gnt("rd1_c1", 1'b0, 1'b0);
        adv();
        @(negedge clock);
        chk_gnt("rd1_c2", 1'b0, 1'b1);
        check_val("rd1_wren", 64'(mem_wren), 64'd0);
        check_val("rd1_addr", 64'(mem_address), 64'd5);
        adv();
        req1 = 0;
        @(negedge clock);
        check_val("rd1_rvalid1", 64'(rvalid1), 64'd1);
        check_val("rd1_rdata1", 64'(rdata1), 64'hDEADBEEF);
        check_val("rd1_rvalid0", 64'(rvalid0), 64'd0);
        check_val("rd1_rdata0", 64'(rdata0), 64'd0);
        adv();
        @(negedge clock);
        check_val("rd1_rvalid1_off", 64'(rvalid1), 64'd0);
        check_val("rd1_rdata1_off", 64'(rdata1), 64'd0);
        adv();

        // Both ports requesting reads continuously
        req0 = 1; req1 = 1; wen0 = 0; wen1 = 0; addr0 = 12'd1; addr1 = 12'd2;
        prev_g0 = 0; prev_g1 = 0;
        for (int i = 0; i < 18; i++) begin
            @(negedge clock);
            if (i == 0) begin
                exp_g0 = 0; exp_g1 = 0;
            end else begin
`ifdef DMEM_ARB_RR_EN
                exp_g0 = (((i - 1) / 4) % 2) == 0;
                exp_g1 = !exp_g0;
`else
                exp_g0 = 1; exp_g1 = 0;
`endif
            end
            exp_addr = exp_g0 ? 12'd1 : (exp_g1 ? 12'd2 : 12'd0);
            chk_gnt($sformatf("both_%0d", i), exp_g0, exp_g1);
            check_val($sformatf("both_addr_%0d", i), 64'(mem_address), 64'(exp_addr));
            check_val($sformatf("both_rv0_%0d", i), 64'(rvalid0), 64'(prev_g0));
            check_val($sformatf("both_rv1_%0d", i), 64'(rvalid1), 64'(prev_g1));
            prev_g0 = exp_g0; prev_g1 = exp_g1;
            adv();
        end
        req0 = 0; req1 = 0;
        @(negedge clock);
        check_val("both_end_rv0", 64'(rvalid0), 64'(prev_g0));
        check_val("both_end_rv1", 64'(rvalid1), 64'(prev_g1));
        adv();

        // Port 1 writes, then port 0 asks during port 1 ownership
        req1 = 1; wen1 = 1; addr1 = 12'd7; wdata1 = 32'h11111111;
        @(negedge clock);
        chk_gnt("pre_c0", 1'b0, 1'b0);
        adv();
        @(negedge clock);
        chk_gnt("pre_c1", 1'b0, 1'b1);
        check_val("pre_c1_wren", 64'(mem_wren), 64'd1);
        adv();
        req0 = 1; wen0 = 0; addr0 = 12'd7;
`ifdef DMEM_ARB_RR_EN
        npre = 4;
        pre_g0[0] = 0; pre_g1[0] = 1;
        pre_g0[1] = 0; pre_g1[1] = 1;
        pre_g0[2] = 0; pre_g1[2] = 1;
        pre_g0[3] = 1; pre_g1[3] = 0;
`else
        npre = 2;
        pre_g0[0] = 0; pre_g1[0] = 1;
        pre_g0[1] = 1; pre_g1[1] = 0;
        pre_g0[2] = 0; pre_g1[2] = 0;
        pre_g0[3] = 0; pre_g1[3] = 0;
`endif
        for (int i = 0; i < npre; i++) begin
            @(negedge clock);
            chk_gnt($sformatf("pre_%0d", i), pre_g0[i], pre_g1[i]);
            adv();
        end
        req0 = 0; req1 = 0;
        @(negedge clock);
        check_val("pre_rvalid0", 64'(rvalid0), 64'd1);
        check_val("pre_rdata0", 64'(rdata0), 64'h11111111);
        check_val("pre_rvalid1", 64'(rvalid1), 64'd0);
        adv();

        // Lone port 1 keeps the port, then hands over as soon as port 0 asks
        req1 = 1; wen1 = 0; addr1 = 12'd5;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            chk_gnt($sformatf("sat_%0d", i), 1'b0, i != 0);
            adv();
        end
        req0 = 1; wen0 = 0; addr0 = 12'd7;
        @(negedge clock);
        chk_gnt("sat_hand0", 1'b0, 1'b1);
        adv();
        @(negedge clock);
        chk_gnt("sat_hand1", 1'b1, 1'b0);
        check_val("sat_last_rvalid1", 64'(rvalid1), 64'd1);
        check_val("sat_last_rdata1", 64'(rdata1), 64'hDEADBEEF);
        adv();
        req0 = 0; req1 = 0;
        @(negedge clock);
        check_val("sat_rvalid0", 64'(rvalid0), 64'd1);
        check_val("sat_rvalid1_off", 64'(rvalid1), 64'd0);
        adv();

        // Reset in the cycle after a port 0 read transfer
        req0 = 1; wen0 = 0; addr0 = 12'd5;
        @(negedge clock);
        chk_gnt("mrst_c0", 1'b0, 1'b0);
        adv();
        @(negedge clock);
        chk_gnt("mrst_c1", 1'b1, 1'b0);
        adv();
        reset = 1'b1;
        @(negedge clock);
        check_val("mrst_rvalid0_pre", 64'(rvalid0), 64'd1);
        check_val("mrst_rdata0_pre", 64'(rdata0), 64'hDEADBEEF);
        adv();
        @(negedge clock);
        check_val("mrst_rvalid0", 64'(rvalid0), 64'd0);
        check_val("mrst_rdata0", 64'(rdata0), 64'd0);
        chk_gnt("mrst", 1'b0, 1'b0);
        check_val("mrst_addr", 64'(mem_address), 64'd0);
        check_val("mrst_wren", 64'(mem_wren), 64'd0);
        adv();
        reset = 1'b0; req0 = 0;
        adv();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
